spi_sclk_engine: RTL and testbench

//  Parametrised successor of the SPI clock generator. It divides clk_in into SCLK and

---
 rtl/spi_sclk_engine_pkg.sv | 18 +
 rtl/spi_sclk_engine_if.sv | 47 ++++
 rtl/spi_sclk_engine_div_cnt.sv | 29 ++
 rtl/spi_sclk_engine.sv | 200 ++++++++++++++++++++
 tb/tb_spi_sclk_engine.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_sclk_engine_pkg.sv
// Shared types and default sizes for the SPI SCLK engine.
// The CS setup/hold states are only reachable when SPI_SCLK_CS_DLY_EN is defined.
package spi_sclk_engine_pkg;

  localparam int unsigned DivWDefault    = 16;
  localparam int unsigned MaxBitsDefault = 128;
  localparam int unsigned DlyWDefault    = 8;

  // 3-bit state encoding; StSetup/StHold exist only in the CS-delay build.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSetup = 3'd1,
    StRun   = 3'd2,
    StTrail = 3'd3,
    StHold  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_sclk_engine_if.sv
// Control/status bundle between the SPI control registers (master) and the
// SCLK engine (slave). cs_dly and DLY_W exist only with SPI_SCLK_CS_DLY_EN.
interface spi_sclk_engine_if
  import spi_sclk_engine_pkg::*;
#(
  parameter int unsigned DIV_W = DivWDefault,
  parameter int unsigned LEN_W = $clog2(MaxBitsDefault)
`ifdef SPI_SCLK_CS_DLY_EN
  ,
  parameter int unsigned DLY_W = DlyWDefault
`endif
);

  logic             go;
  logic             abort;
  logic [DIV_W-1:0] divider;
  logic             cpol;
  logic             cpha;
  logic [LEN_W-1:0] char_len;
`ifdef SPI_SCLK_CS_DLY_EN
  logic [DLY_W-1:0] cs_dly;
`endif
  logic             sclk;
  logic             busy;
  logic             load;
  logic             shift;
  logic             sample;
  logic [LEN_W-1:0] bit_idx;
  logic             done;

  modport master (
`ifdef SPI_SCLK_CS_DLY_EN
    output cs_dly,
`endif
    output go, abort, divider, cpol, cpha, char_len,
    input  sclk, busy, load, shift, sample, bit_idx, done
  );

  modport slave (
`ifdef SPI_SCLK_CS_DLY_EN
    input  cs_dly,
`endif
    input  go, abort, divider, cpol, cpha, char_len,
    output sclk, busy, load, shift, sample, bit_idx, done
  );

endinterface

// File: rtl/spi_sclk_engine_div_cnt.sv
// Reloadable half-period down-counter. Loads val on load; when enabled it
// reloads val on zero and otherwise decrements, so one period spans val+1 cycles.
module spi_sclk_engine_div_cnt #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] val,
  output logic             zero
);

  logic [DIV_W-1:0] cnt_q;

  // Counter state: explicit load wins over the free-running reload/decrement.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '1;
    end else if (load) begin
      cnt_q <= val;
    end else if (en) begin
      cnt_q <= zero ? val : cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/spi_sclk_engine.sv
// SPI SCLK engine: divides clk_in into SCLK for all four CPOL/CPHA modes,
// counts bits and emits registered load/shift/sample/done strobes that are
// coincident with the SCLK transition they mark.
// Optional feature: define SPI_SCLK_CS_DLY_EN to add CS setup/hold delay states.
module spi_sclk_engine
  import spi_sclk_engine_pkg::*;
#(
  parameter int unsigned DIV_W    = DivWDefault,
  parameter int unsigned MAX_BITS = MaxBitsDefault,
`ifdef SPI_SCLK_CS_DLY_EN
  parameter int unsigned DLY_W    = DlyWDefault,
`endif
  localparam int unsigned LEN_W   = $clog2(MAX_BITS)
) (
  input logic              clk_in,
  input logic              rst_n,
  spi_sclk_engine_if.slave bus
);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic             cpol_q;
  logic             cpha_q;
  logic [LEN_W-1:0] last_q;   // N-1 for the current transfer
  logic [LEN_W-1:0] pair_q;   // trailing edges completed so far
  logic             sclk_q;
  logic             busy_q;
  logic             load_q;
  logic             shift_q;
  logic             sample_q;
  logic             done_q;
  logic [LEN_W-1:0] bit_idx_q;
`ifdef SPI_SCLK_CS_DLY_EN
  logic [DLY_W-1:0] cs_dly_q;
  logic [DLY_W-1:0] dly_q;
`endif

  logic             start;
  logic             cnt_en;
  logic             cnt_zero;
  logic [DIV_W-1:0] cnt_val;
  logic [LEN_W-1:0] char_last;
  logic             leading;

  // Acceptance, counter control and edge classification.
  always_comb begin
    start     = (state_q == StIdle) && bus.go && !bus.abort;
    cnt_en    = ((state_q == StRun) || (state_q == StTrail)) && !bus.abort;
    cnt_val   = start ? bus.divider : div_q;
    char_last = (bus.char_len == '0) ? LEN_W'(MAX_BITS - 1) : bus.char_len - 1'b1;
    // SCLK still at its idle level means the next toggle is a leading edge.
    leading   = (sclk_q == cpol_q);
  end

  spi_sclk_engine_div_cnt #(
    .DIV_W (DIV_W)
  ) u_div_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .load   (start),
    .en     (cnt_en),
    .val    (cnt_val),
    .zero   (cnt_zero)
  );

  // Transfer FSM with registered SCLK, status and strobes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      last_q    <= '0;
      pair_q    <= '0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
`ifdef SPI_SCLK_CS_DLY_EN
      cs_dly_q  <= '0;
      dly_q     <= '0;
`endif
    end else begin
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      done_q   <= 1'b0;
      if (sample_q && (bit_idx_q != last_q)) begin
        bit_idx_q <= bit_idx_q + 1'b1;
      end
      if (bus.abort && (state_q != StIdle)) begin
        state_q <= StIdle;
        sclk_q  <= bus.cpol;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            sclk_q <= bus.cpol;
            if (start) begin
              div_q     <= bus.divider;
              cpol_q    <= bus.cpol;
              cpha_q    <= bus.cpha;
              last_q    <= char_last;
              pair_q    <= '0;
              bit_idx_q <= '0;
              busy_q    <= 1'b1;
              load_q    <= 1'b1;
`ifdef SPI_SCLK_CS_DLY_EN
              cs_dly_q  <= bus.cs_dly;
              dly_q     <= bus.cs_dly;
              state_q   <= (bus.cs_dly == '0) ? StRun : StSetup;
`else
              state_q   <= StRun;
`endif
            end
          end
`ifdef SPI_SCLK_CS_DLY_EN
          // Counter holds its loaded value until setup delay elapses.
          StSetup: begin
            if (dly_q <= DLY_W'(1)) begin
              state_q <= StRun;
            end else begin
              dly_q <= dly_q - 1'b1;
            end
          end
`endif
          StRun: begin
            if (cnt_zero) begin
              sclk_q <= ~sclk_q;
              if (leading) begin
                if (!cpha_q) begin
                  sample_q <= 1'b1;
                end else if (pair_q != '0) begin
                  shift_q <= 1'b1;
                end
              end else begin
                if (cpha_q) begin
                  sample_q <= 1'b1;
                end
                if (pair_q == last_q) begin
                  state_q <= StTrail;
                end else begin
                  pair_q <= pair_q + 1'b1;
                  if (!cpha_q) begin
                    shift_q <= 1'b1;
                  end
                end
              end
            end
          end
          StTrail: begin
            if (cnt_zero) begin
`ifdef SPI_SCLK_CS_DLY_EN
              if (cs_dly_q != '0) begin
                state_q <= StHold;
                dly_q   <= cs_dly_q;
              end else begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
`else
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end
          end
`ifdef SPI_SCLK_CS_DLY_EN
          StHold: begin
            if (dly_q <= DLY_W'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              dly_q <= dly_q - 1'b1;
            end
          end
`endif
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sclk    = sclk_q;
  assign bus.busy    = busy_q;
  assign bus.load    = load_q;
  assign bus.shift   = shift_q;
  assign bus.sample  = sample_q;
  assign bus.bit_idx = bit_idx_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: expected edge/strobe/done timing is
// computed from the transfer parameters (edge k at T+1+k*(divider+1)).
module tb_spi_sclk_engine;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk_in = ~clk_in;

`ifdef SPI_SCLK_CS_DLY_EN
  spi_sclk_engine_if #(.DIV_W(16), .LEN_W(7), .DLY_W(8)) bus ();
  spi_sclk_engine #(.DIV_W(16), .MAX_BITS(128), .DLY_W(8)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );
`else
  spi_sclk_engine_if #(.DIV_W(16), .LEN_W(7)) bus ();
  spi_sclk_engine #(.DIV_W(16), .MAX_BITS(128)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );
`endif

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // stop_mode: 0 full transfer, 1 abort at stop_edge, 2 reset pulse at stop_edge.
  task automatic run_xfer(input string tag, input int d, input bit pol, input bit pha,
                          input int len, input int cs, input int stop_edge,
                          input int stop_mode, input bit disturb);
    int   n, hp, done_rel, k, off;
    int   samples, shifts, loads, dones, done_at, pos_err, strobe_err, busy_err, idx_err;
    int   max_idx;
    bit   exp_edge, exp_sample, exp_shift, exp_busy, is_edge;
    logic prev_sclk, sclk_done;
    n = (len == 0) ? 128 : len;
    hp = d + 1;
    done_rel = 1 + 2 * cs + (2 * n + 1) * hp;
    samples = 0; shifts = 0; loads = 0; dones = 0; done_at = -1;
    pos_err = 0; strobe_err = 0; busy_err = 0; idx_err = 0; max_idx = 0;
    sclk_done = ~pol;
    bus.divider  = 16'(d);
    bus.cpol     = pol;
    bus.cpha     = pha;
    bus.char_len = 7'(len);
`ifdef SPI_SCLK_CS_DLY_EN
    bus.cs_dly   = 8'(cs);
`endif
    bus.go = 1'b1;
    prev_sclk = pol;
    for (int rel = 1; rel <= done_rel + 3; rel++) begin
      tick();
      if (rel == 1) bus.go = 1'b0;
      off = rel - 1 - cs;
      k = (off > 0 && off % hp == 0) ? off / hp : 0;
      exp_edge   = (k >= 1) && (k <= 2 * n);
      exp_sample = exp_edge && (pha ? (k % 2 == 0) : (k % 2 == 1));
      exp_shift  = exp_edge && (pha ? (k % 2 == 1 && k > 1) : (k % 2 == 0 && k < 2 * n));
      exp_busy   = (rel < done_rel);
      is_edge    = (bus.sclk !== prev_sclk);
      prev_sclk  = bus.sclk;
      if (is_edge != exp_edge) pos_err++;
      if ((bus.sample !== exp_sample) || (bus.shift !== exp_shift)) strobe_err++;
      if (bus.shift === 1'b1) shifts++;
      if (bus.sample === 1'b1) begin
        if (int'(bus.bit_idx) != samples) idx_err++;
        samples++;
      end
      if (bus.load === 1'b1) begin
        loads++;
        if (rel != 1) strobe_err++;
      end
      if (bus.done === 1'b1) begin
        dones++;
        done_at = rel;
      end
      if (bus.busy !== exp_busy) busy_err++;
      if (bus.busy === 1'b1 && int'(bus.bit_idx) > max_idx) max_idx = int'(bus.bit_idx);
      if (rel == done_rel) sclk_done = bus.sclk;
      if (stop_mode != 0 && k == stop_edge) begin
        check({tag, "_pre_edges"}, pos_err, 0);
        check({tag, "_pre_strobes"}, strobe_err, 0);
        if (stop_mode == 1) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
          check({tag, "_abort_busy"}, bus.busy, 0);
          check({tag, "_abort_sclk"}, bus.sclk, pol);
          check({tag, "_abort_strobes"},
                {bus.load, bus.shift, bus.sample, bus.done}, 0);
          // abort must win over go while idle
          bus.go = 1'b1;
          bus.abort = 1'b1;
          tick();
          bus.go = 1'b0;
          bus.abort = 1'b0;
          check({tag, "_prio_busy"}, bus.busy, 0);
          check({tag, "_prio_load"}, bus.load, 0);
        end else begin
          rst_n = 1'b0;
          #1;
          check({tag, "_rst_sclk"}, bus.sclk, 0);
          check({tag, "_rst_busy"}, bus.busy, 0);
          check({tag, "_rst_idx"}, bus.bit_idx, 0);
          check({tag, "_rst_strobes"}, {bus.load, bus.shift, bus.sample, bus.done}, 0);
          #2;
          rst_n = 1'b1;
        end
        return;
      end
      if (disturb) begin
        if (rel == 3) begin
          bus.go = 1'b1;
          bus.divider = ~16'(d);
          bus.cpol = ~pol;
          bus.cpha = ~pha;
          bus.char_len = 7'(len + 3);
        end
        if (rel == 4) bus.go = 1'b0;
        // restore and pulse go while TRAIL is about to finish
        if (rel == done_rel - 1) begin
          bus.go = 1'b1;
          bus.divider = 16'(d);
          bus.cpol = pol;
          bus.cpha = pha;
          bus.char_len = 7'(len);
        end
        if (rel == done_rel) bus.go = 1'b0;
      end
    end
    check({tag, "_edge_pos"}, pos_err, 0);
    check({tag, "_strobe_pos"}, strobe_err, 0);
    check({tag, "_busy"}, busy_err, 0);
    check({tag, "_samples"}, samples, n);
    check({tag, "_shifts"}, shifts, n - 1);
    check({tag, "_loads"}, loads, 1);
    check({tag, "_dones"}, dones, 1);
    check({tag, "_done_at"}, done_at, done_rel);
    check({tag, "_idx_at_sample"}, idx_err, 0);
    check({tag, "_max_idx"}, max_idx, n - 1);
    check({tag, "_sclk_done"}, sclk_done, pol);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.go = 1'b0;
    bus.abort = 1'b0;
    bus.divider = '0;
    bus.cpol = 1'b0;
    bus.cpha = 1'b0;
    bus.char_len = '0;
`ifdef SPI_SCLK_CS_DLY_EN
    bus.cs_dly = '0;
`endif
    #12;
    check("rst_sclk", bus.sclk, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_load", bus.load, 0);
    check("rst_shift", bus.shift, 0);
    check("rst_sample", bus.sample, 0);
    check("rst_done", bus.done, 0);
    check("rst_idx", bus.bit_idx, 0);
    rst_n = 1'b1;
    tick();
    tick();

    run_xfer("t1_d0_m0_n8", 0, 1'b0, 1'b0, 8, 0, 0, 0, 1'b0);
    run_xfer("t2_d3_m3_n4", 3, 1'b1, 1'b1, 4, 0, 0, 0, 1'b0);
    run_xfer("t3_len0", 0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    run_xfer("t4_abort", 2, 1'b1, 1'b0, 5, 0, 3, 1, 1'b0);
    run_xfer("t4_after_abort", 2, 1'b1, 1'b0, 5, 0, 0, 0, 1'b0);
    run_xfer("t4_rst", 1, 1'b0, 1'b1, 3, 0, 3, 2, 1'b0);
    run_xfer("t4_after_rst", 1, 1'b0, 1'b1, 3, 0, 0, 0, 1'b0);
    run_xfer("t5_disturb", 3, 1'b0, 1'b1, 6, 0, 0, 0, 1'b1);
    run_xfer("n1_d2_m3", 2, 1'b1, 1'b1, 1, 0, 0, 0, 1'b0);
    run_xfer("n1_d0_m0", 0, 1'b0, 1'b0, 1, 0, 0, 0, 1'b0);
`ifdef SPI_SCLK_CS_DLY_EN
    run_xfer("t6_cs5", 0, 1'b0, 1'b0, 2, 5, 0, 0, 1'b0);
    run_xfer("t6_cs0", 0, 1'b0, 1'b0, 2, 0, 0, 0, 1'b0);
`endif
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
